// File: rtl/aes_mem_ctrl.sv
// Streams plaintext words from RAM into 128-bit blocks for a cipher core and
// writes the ciphertext back, closing the output with a terminator word.
module aes_mem_ctrl #(
   parameter logic [9:0]  IN_BASE   = 10'd0,
   parameter logic [9:0]  OUT_BASE  = 10'd257,
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] TERM      = 32'hDEADBEEF,
   parameter int unsigned RD_LAT    = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start_in,
   output logic         busy_out,
   output logic         done_out,
   output logic [8:0]   words_out,
   output logic [9:0]   mem_addr_out,
   output logic [3:0]   mem_we_out,
   output logic [31:0]  mem_data_out,
   input  logic [31:0]  mem_data_in,
   output logic [127:0] aes_block_out,
   output logic         aes_valid_out,
   input  logic         aes_ready_in,
   input  logic [127:0] aes_result_in,
   input  logic         aes_result_valid_in
);

   localparam int unsigned   WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);
   localparam logic [8:0]    MAXW      = 9'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_WAIT, SEND, WAIT_RES, WR, WR_TERM, DONE
   } state_t;

   state_t          state_q, state_d;
   logic [8:0]      rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d, words_q, words_d;
   logic [2:0]      k_q, k_d;
   logic [1:0]      wcnt_q, wcnt_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            last_q, last_d;
   logic [127:0]    blk_q, blk_d, res_q, res_d;
   logic [8:0]      rd_inc;

   assign rd_inc        = rd_idx_q + 9'd1;
   assign aes_block_out = blk_q;
   assign words_out     = words_q;

   always_comb begin
      state_d       = state_q;
      rd_idx_d      = rd_idx_q;
      wr_idx_d      = wr_idx_q;
      words_d       = words_q;
      k_d           = k_q;
      wcnt_d        = wcnt_q;
      wait_d        = wait_q;
      last_d        = last_q;
      blk_d         = blk_q;
      res_d         = res_q;
      busy_out      = (state_q != IDLE);
      done_out      = 1'b0;
      mem_addr_out  = '0;
      mem_we_out    = '0;
      mem_data_out  = '0;
      aes_valid_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               rd_idx_d = '0;
               wr_idx_d = '0;
               k_d      = '0;
               last_d   = 1'b0;
               blk_d    = '0;
               state_d  = RD_ADDR;
            end
         end
         RD_ADDR: begin
            mem_addr_out = IN_BASE + {1'b0, rd_idx_q};
            wait_d       = '0;
            state_d      = RD_WAIT;
         end
         RD_WAIT: begin
            mem_addr_out = IN_BASE + {1'b0, rd_idx_q};
            if (wait_q != WAIT_LAST) begin
               wait_d = wait_q + 1'b1;
            end else if (mem_data_in == TERM) begin
               if (k_q != 3'd0) begin
                  last_d  = 1'b1;
                  state_d = SEND;
               end else begin
                  state_d = WR_TERM;
               end
            end else begin
               // Slot 0 store also zeroes the rest, so short last blocks are padded
               case (k_q[1:0])
                  2'd0: blk_d = {mem_data_in, 96'h0};
                  2'd1: blk_d[95:64] = mem_data_in;
                  2'd2: blk_d[63:32] = mem_data_in;
                  default: blk_d[31:0] = mem_data_in;
               endcase
               rd_idx_d = rd_inc;
               k_d      = k_q + 3'd1;
               // Hitting the word limit acts like a terminator without another read
               if (k_q == 3'd3) begin
                  last_d  = (rd_inc == MAXW);
                  state_d = SEND;
               end else if (rd_inc == MAXW) begin
                  last_d  = 1'b1;
                  state_d = SEND;
               end else begin
                  state_d = RD_ADDR;
               end
            end
         end
         SEND: begin
            aes_valid_out = 1'b1;
            if (aes_ready_in) state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (aes_result_valid_in) begin
               res_d   = aes_result_in;
               wcnt_d  = '0;
               state_d = WR;
            end
         end
         WR: begin
            mem_addr_out = OUT_BASE + {1'b0, wr_idx_q};
            mem_we_out   = 4'hF;
            case (wcnt_q)
               2'd0: mem_data_out = res_q[127:96];
               2'd1: mem_data_out = res_q[95:64];
               2'd2: mem_data_out = res_q[63:32];
               default: mem_data_out = res_q[31:0];
            endcase
            wr_idx_d = wr_idx_q + 9'd1;
            wcnt_d   = wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) begin
               k_d     = '0;
               state_d = last_q ? WR_TERM : RD_ADDR;
            end
         end
         WR_TERM: begin
            mem_addr_out = OUT_BASE + {1'b0, wr_idx_q};
            mem_we_out   = 4'hF;
            mem_data_out = TERM;
            words_d      = wr_idx_q;
            state_d      = DONE;
         end
         DONE: begin
            done_out = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         words_q  <= '0;
         k_q      <= '0;
         wcnt_q   <= '0;
         wait_q   <= '0;
         last_q   <= 1'b0;
         blk_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         words_q  <= words_d;
         k_q      <= k_d;
         wcnt_q   <= wcnt_d;
         wait_q   <= wait_d;
         last_q   <= last_d;
         blk_q    <= blk_d;
         res_q    <= res_d;
      end
   end

endmodule

// File: tb/tb_aes_mem_ctrl.sv
// Scoreboard bench for aes_mem_ctrl: a latency-2 RAM model and a toy cipher
// responder; expected blocks and RAM writes are queued when each job is prepared.
module tb_aes_mem_ctrl;

   localparam logic [9:0]  IN_BASE  = 10'd0;
   localparam logic [9:0]  OUT_BASE = 10'd257;
   localparam logic [31:0] TERM     = 32'hDEADBEEF;
   localparam int          MAXW     = 256;

   logic         clk_in = 1'b0;
   logic         rst_in, start_in;
   logic         busy_out, done_out;
   logic [8:0]   words_out;
   logic [9:0]   mem_addr_out;
   logic [3:0]   mem_we_out;
   logic [31:0]  mem_data_out, mem_data_in;
   logic [127:0] aes_block_out, aes_result_in;
   logic         aes_valid_out, aes_ready_in, aes_result_valid_in;

   always #5 clk_in = ~clk_in;

   aes_mem_ctrl #(
      .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .MAX_WORDS(MAXW), .TERM(TERM), .RD_LAT(2)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
      .busy_out(busy_out), .done_out(done_out), .words_out(words_out),
      .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .aes_block_out(aes_block_out), .aes_valid_out(aes_valid_out),
      .aes_ready_in(aes_ready_in), .aes_result_in(aes_result_in),
      .aes_result_valid_in(aes_result_valid_in)
   );

   // two-cycle read latency RAM (input side only; writes go to the scoreboard)
   logic [31:0] in_mem [0:1023];
   logic [31:0] rd_p0, rd_p1;
   always @(posedge clk_in) begin
      rd_p0 <= in_mem[mem_addr_out];
      rd_p1 <= rd_p0;
   end
   assign mem_data_in = rd_p1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_done, n_sent, ready_delay;
   bit rd256;
   logic [9:0]   exp_addr_q [$];
   logic [31:0]  exp_data_q [$];
   logic [127:0] exp_blk_q  [$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] cipher(input logic [127:0] b);
      return {b[95:0], b[127:96]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   endfunction

   always @(negedge clk_in) begin
      if (done_out) n_done++;
      if (busy_out && mem_we_out == 4'h0 && mem_addr_out == 10'd256) rd256 = 1'b1;
      if (mem_we_out != 4'h0) begin
         if (exp_addr_q.size() == 0) chk("wr_pending", 128'(exp_addr_q.size() != 0), 128'd1);
         else chk("ram_write", {mem_we_out, mem_addr_out, mem_data_out},
                  {4'hF, exp_addr_q.pop_front(), exp_data_q.pop_front()});
      end
   end

   initial begin : aes_model
      logic [127:0] blk;
      bit stable;
      aes_ready_in = 1'b0; aes_result_valid_in = 1'b0; aes_result_in = '0;
      forever begin
         @(negedge clk_in);
         if (aes_valid_out && !rst_in) begin
            blk = aes_block_out;
            n_sent++;
            if (exp_blk_q.size() == 0) chk("blk_pending", 128'(exp_blk_q.size() != 0), 128'd1);
            else chk("aes_block", blk, exp_blk_q.pop_front());
            stable = 1'b1;
            for (int i = 0; i < ready_delay; i++) begin
               // stray strobe while the block is still pending must be ignored
               aes_result_valid_in = (i == 0);
               aes_result_in = {4{$urandom}};
               @(negedge clk_in);
               if (!aes_valid_out || aes_block_out !== blk) stable = 1'b0;
            end
            aes_result_valid_in = 1'b0;
            if (ready_delay > 0) chk("valid_hold", 128'(stable), 128'd1);
            aes_ready_in = 1'b1;
            @(negedge clk_in);
            aes_ready_in = 1'b0;
            chk("valid_drop", aes_valid_out, 0);
            repeat (2) @(negedge clk_in);
            aes_result_in = cipher(blk);
            aes_result_valid_in = 1'b1;
            @(negedge clk_in);
            aes_result_valid_in = 1'b0;
            aes_result_in = {4{$urandom}};
         end
      end
   end

   task automatic prep(input int n, input bit seq, input bit put_term,
                       output int nb, output int exp_words);
      logic [127:0] blk, r;
      int nw;
      for (int i = 0; i < n; i++)
         in_mem[IN_BASE + 10'(i)] = seq ? 32'(i + 1) : ($urandom & 32'h7FFF_FFFF);
      if (put_term) in_mem[IN_BASE + 10'(n)] = TERM;
      nw = (n > MAXW) ? MAXW : n;
      nb = (nw + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int j = 0; j < 4; j++)
            if (4 * b + j < nw) blk[127 - 32 * j -: 32] = in_mem[IN_BASE + 10'(4 * b + j)];
         exp_blk_q.push_back(blk);
         r = cipher(blk);
         for (int j = 0; j < 4; j++) begin
            exp_addr_q.push_back(OUT_BASE + 10'(4 * b + j));
            exp_data_q.push_back(r[127 - 32 * j -: 32]);
         end
      end
      exp_addr_q.push_back(OUT_BASE + 10'(4 * nb));
      exp_data_q.push_back(TERM);
      exp_words = 4 * nb;
   endtask

   task automatic run(input int nb, input int exp_words, input bit poke_start);
      int cyc;
      n_done = 0; n_sent = 0; rd256 = 1'b0;
      @(negedge clk_in) start_in = 1'b1;
      @(negedge clk_in) start_in = 1'b0;
      chk("busy_after_start", busy_out, 1);
      cyc = 0;
      while (!done_out && cyc < 20000) begin
         @(negedge clk_in);
         cyc++;
         start_in = (poke_start && cyc == 5);
      end
      start_in = 1'b0;
      chk("done_seen", done_out, 1);
      chk("words_out", words_out, exp_words);
      repeat (3) @(negedge clk_in);
      chk("done_count", n_done, 1);
      chk("idle_after_done", busy_out, 0);
      chk("blocks_sent", n_sent, nb);
      chk("writes_left", exp_addr_q.size(), 0);
   endtask

   initial begin : main
      int nb, ew, cyc;
      rst_in = 1'b1; start_in = 1'b0; ready_delay = 0;
      n_done = 0; n_sent = 0; rd256 = 1'b0;
      for (int a = 0; a < 1024; a++) in_mem[a] = 32'h1000_0000 + 32'(a);
      repeat (3) @(negedge clk_in);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      chk("rst_valid", aes_valid_out, 0);
      chk("rst_we", mem_we_out, 0);
      chk("rst_addr", mem_addr_out, 0);
      chk("rst_data", mem_data_out, 0);
      chk("rst_block", aes_block_out, 0);
      chk("rst_words", words_out, 0);
      rst_in = 1'b0;
      @(negedge clk_in);

      prep(8, 1'b1, 1'b1, nb, ew);     // words 1..8 then TERM
      run(nb, ew, 1'b0);

      ready_delay = 10;                // 5 words, ready stalled, start poked while busy
      prep(5, 1'b0, 1'b1, nb, ew);
      run(nb, ew, 1'b1);
      ready_delay = 1;

      prep(0, 1'b0, 1'b1, nb, ew);     // TERM at address 0
      run(nb, ew, 1'b0);

      prep(256, 1'b0, 1'b0, nb, ew);   // no terminator: limit forces it
      run(nb, ew, 1'b0);
      chk("addr256_unread", 128'(rd256), 0);

      prep(12, 1'b0, 1'b1, nb, ew);    // reset during the first write burst
      n_done = 0;
      @(negedge clk_in) start_in = 1'b1;
      @(negedge clk_in) start_in = 1'b0;
      cyc = 0;
      while (mem_we_out == 4'h0 && cyc < 2000) begin
         @(negedge clk_in);
         cyc++;
      end
      chk("reach_wr", 128'(mem_we_out != 4'h0), 1);
      rst_in = 1'b1;
      @(negedge clk_in);
      exp_addr_q.delete(); exp_data_q.delete(); exp_blk_q.delete();
      chk("abort_busy", busy_out, 0);
      chk("abort_we", mem_we_out, 0);
      chk("abort_done", done_out, 0);
      rst_in = 1'b0;
      repeat (20) @(negedge clk_in);
      chk("abort_no_done", n_done, 0);
      chk("abort_idle", busy_out, 0);

      prep(6, 1'b1, 1'b1, nb, ew);
      run(nb, ew, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_mem_ctrl.md
AES_MEM_CTRL -- requirements
Module: aes_mem_ctrl

Interface
REQ-001 SHALL have parameter IN_BASE, default 10'd0, word address of first plaintext word.
REQ-002 SHALL have parameter OUT_BASE, default 10'd257, word address of first ciphertext word.
REQ-003 SHALL have parameter MAX_WORDS, default 256, input words scanned before a terminator is forced.
REQ-004 SHALL have parameter TERM, default 32'hDEADBEEF, terminator word value.
REQ-005 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles.
REQ-006 SHALL have ports:
- clk_in  input  1  sole clock.
- rst_in  input  1  reset; synchronous, active-high.
- start_in  input  1  one-cycle job request.
- busy_out  output  1  job in progress.
- done_out  output  1  one-cycle job-complete pulse.
- words_out  output  9  ciphertext words written by the last job.
- mem_addr_out  output  10  AES-side RAM word address.
- mem_we_out  output  4  AES-side RAM byte write enables.
- mem_data_out  output  32  AES-side RAM write data.
- mem_data_in  input  32  AES-side RAM read data.
- aes_block_out  output  128  plaintext block to the cipher core.
- aes_valid_out  output  1  aes_block_out valid.
- aes_ready_in  input  1  cipher core accepts the block.
- aes_result_in  input  128  ciphertext block.
- aes_result_valid_in  input  1  one-cycle ciphertext-valid strobe.

Function
REQ-007 SHALL implement FSM states IDLE, RD_ADDR, RD_WAIT, SEND, WAIT_RES, WR, WR_TERM, DONE.
REQ-008 SHALL leave IDLE for RD_ADDR on start_in=1, clearing the read index, write index and word slot; start_in outside IDLE SHALL be ignored.
REQ-009 In RD_ADDR SHALL drive mem_addr_out=IN_BASE+read index with mem_we_out=0, then spend exactly RD_LAT cycles in RD_WAIT before sampling mem_data_in.
REQ-010 A sampled word not equal to TERM SHALL be stored in slot k (0..3), with slot 0 at bits [127:96] and slot 3 at bits [31:0]; read index and k increment.
REQ-011 When k reaches 4 SHALL go to SEND; otherwise SHALL go to RD_ADDR.
REQ-012 A sampled TERM SHALL end input; if k>0, unfilled slots SHALL be zero and the FSM SHALL go to SEND (last block); if k=0 SHALL go to WR_TERM.
REQ-013 When the read index reaches MAX_WORDS without a TERM, the FSM SHALL behave as if TERM were sampled next, with no further read.
REQ-014 In SEND SHALL hold aes_valid_out=1 and aes_block_out stable until the cycle aes_ready_in=1, then deassert aes_valid_out and go to WAIT_RES.
REQ-015 In WAIT_RES SHALL capture aes_result_in on aes_result_valid_in=1 and go to WR; result strobes in any other state SHALL be ignored.
REQ-016 In WR SHALL write the 4 result words in 4 consecutive cycles, highest bits first, to OUT_BASE+write index, with mem_we_out=4'hF; write index increments per word.
REQ-017 After WR SHALL return to RD_ADDR, or SHALL go to WR_TERM if the block was the last block.
REQ-018 In WR_TERM SHALL write TERM to OUT_BASE+write index for one cycle, latch words_out=write index, then enter DONE.
REQ-019 DONE SHALL last one cycle with done_out=1, then return to IDLE.
REQ-020 busy_out SHALL be 1 in every state except IDLE.
REQ-021 mem_we_out SHALL be nonzero only in WR and WR_TERM.
REQ-022 The write index SHALL never exceed 256, so the highest address written is OUT_BASE+256.

Reset
REQ-023 In any state, rst_in=1 SHALL force IDLE and clear all of: busy_out, done_out, aes_valid_out, mem_we_out, mem_addr_out, mem_data_out, aes_block_out, words_out, all indices and slots.
REQ-024 A reset mid-job SHALL abort it with no further RAM writes and no done_out pulse.

Verification
REQ-025 Input 8 words 1..8, then TERM at address 8 -> 2 blocks sent; 8 ciphertext words at 257..264; DEADBEEF at 265; words_out=8; one done_out pulse.
REQ-026 Input 5 words then TERM -> second block = {w4,0,0,0}; words_out=8; TERM at 265.
REQ-027 TERM at address 0 -> no aes_valid_out; DEADBEEF at 257; words_out=0.
REQ-028 256 words with no TERM -> 64 blocks; TERM at 513; words_out=256; address 256 never read.
REQ-029 aes_ready_in held low 10 cycles -> aes_valid_out stays 1 and aes_block_out stays constant; also check start_in pulses while busy are ignored.
REQ-030 rst_in asserted during WR -> next cycle IDLE, mem_we_out=0, no done_out; a following start_in runs a clean job.
